mul_div_ctrl: RTL and testbench

MUL_DIV_CTRL -- requirements
Module: mul_div_ctrl

---
 rtl/mul_div_ctrl.sv | 155 +++++++++++++++
 tb/tb_mul_div_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mul_div_ctrl.sv
// RV32M multiply/divide unit for a single-issue EX stage.
// Multiplication uses iterative shift-add. Division uses restoring division.
// Each op takes one accept cycle and 32 iteration cycles, then a one-cycle
// DONE strobe. Divide-by-zero and signed overflow can optionally finish
// straight from IDLE.
module mul_div_ctrl #(
    parameter bit FAST_SPECIAL = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_valid,
    input  logic [2:0]  i_func3,
    input  logic [31:0] i_rs1_data,
    input  logic [31:0] i_rs2_data,
    input  logic        i_flush,
    output logic        o_stall,
    output logic        o_busy,
    output logic        o_valid,
    output logic [31:0] o_result
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t      r_state, w_state_next;
    logic [4:0]  r_cnt;
    logic [2:0]  r_func3;
    logic [63:0] r_acc;          // mul: {partial hi, multiplier}; div: {remainder, dividend/quotient}
    logic [31:0] r_b;            // mul: multiplicand magnitude; div: divisor magnitude
    logic        r_neg_q;        // negate product / quotient
    logic        r_neg_r;        // negate remainder (dividend sign)
    logic        r_special;
    logic [31:0] r_special_val;
    logic [31:0] r_result;

    // ---------------- accept-side decode ----------------
    logic        w_accept, w_a_signed, w_b_signed, w_sign_a, w_sign_b;
    logic [31:0] w_mag_a, w_mag_b, w_special_val;
    logic        w_div_zero, w_div_ovf, w_special, w_fast;

    assign w_accept   = (r_state == S_IDLE) && i_valid && !i_flush;
    assign w_a_signed = (i_func3 == 3'b001) || (i_func3 == 3'b010) ||
                        (i_func3 == 3'b100) || (i_func3 == 3'b110);
    assign w_b_signed = (i_func3 == 3'b001) || (i_func3 == 3'b100) || (i_func3 == 3'b110);
    assign w_sign_a   = w_a_signed && i_rs1_data[31];
    assign w_sign_b   = w_b_signed && i_rs2_data[31];
    assign w_mag_a    = w_sign_a ? (~i_rs1_data + 32'd1) : i_rs1_data;
    assign w_mag_b    = w_sign_b ? (~i_rs2_data + 32'd1) : i_rs2_data;
    assign w_div_zero = i_func3[2] && (i_rs2_data == 32'd0);
    assign w_div_ovf  = i_func3[2] && !i_func3[0] &&
                        (i_rs1_data == 32'h8000_0000) && (i_rs2_data == 32'hFFFF_FFFF);
    assign w_special  = w_div_zero || w_div_ovf;
    assign w_fast     = FAST_SPECIAL && w_special;

    // Quotient of x/0 is all ones, remainder is the dividend; overflow gives MIN / 0.
    assign w_special_val = w_div_zero ? (i_func3[1] ? i_rs1_data : 32'hFFFF_FFFF)
                                      : (i_func3[1] ? 32'd0 : 32'h8000_0000);

    // ---------------- one iteration step ----------------
    logic [32:0] w_mul_sum, w_rem_sh;
    logic [31:0] w_diff;
    logic        w_ge;
    logic [63:0] w_acc_next, w_prod;
    logic [31:0] w_quo, w_rem, w_final;

    assign w_mul_sum  = {1'b0, r_acc[63:32]} + {1'b0, (r_acc[0] ? r_b : 32'd0)};
    assign w_rem_sh   = r_acc[63:31];
    assign w_ge       = (w_rem_sh >= {1'b0, r_b});
    assign w_diff     = w_rem_sh[31:0] - r_b;
    assign w_acc_next = r_func3[2] ? {(w_ge ? w_diff : w_rem_sh[31:0]), r_acc[30:0], w_ge}
                                   : {w_mul_sum, r_acc[31:1]};

    assign w_prod = r_neg_q ? (~w_acc_next + 64'd1) : w_acc_next;
    assign w_quo  = r_neg_q ? (~w_acc_next[31:0] + 32'd1) : w_acc_next[31:0];
    assign w_rem  = r_neg_r ? (~w_acc_next[63:32] + 32'd1) : w_acc_next[63:32];

    // Select the architectural result from the final iteration
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_final = w_prod[63:32];
        case (r_func3)
            3'b000:         w_final = w_prod[31:0];
            3'b100, 3'b101: w_final = w_quo;
            3'b110, 3'b111: w_final = w_rem;
            default:        w_final = w_prod[63:32];
        endcase
        if (r_special) w_final = r_special_val;
    end

    // ---------------- FSM ----------------
    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state logic; flush always returns to IDLE
    always_comb begin
        w_state_next = r_state;
        if (i_flush) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (i_valid) w_state_next = w_fast ? S_DONE : S_BUSY;
                S_BUSY:  if (r_cnt == 5'd31) w_state_next = S_DONE;
                S_DONE:  w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // Output decode
    always_comb begin
        o_busy   = (r_state != S_IDLE);
        o_stall  = w_accept || (r_state == S_BUSY);
        o_valid  = (r_state == S_DONE) && !i_flush;
        o_result = o_valid ? r_result : 32'd0;
    end

    // ---------------- datapath registers ----------------
    // Latch operands on accept, iterate while BUSY, and capture the final result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= 5'd0;
            r_func3       <= 3'd0;
            r_acc         <= 64'd0;
            r_b           <= 32'd0;
            r_neg_q       <= 1'b0;
            r_neg_r       <= 1'b0;
            r_special     <= 1'b0;
            r_special_val <= 32'd0;
            r_result      <= 32'd0;
        end else if (w_accept) begin
            r_cnt         <= 5'd0;
            r_func3       <= i_func3;
            r_neg_q       <= w_sign_a ^ w_sign_b;
            r_neg_r       <= w_sign_a;
            r_special     <= w_special;
            r_special_val <= w_special_val;
            if (i_func3[2]) begin
                r_acc <= {32'd0, w_mag_a};
                r_b   <= w_mag_b;
            end else begin
                r_acc <= {32'd0, w_mag_b};
                r_b   <= w_mag_a;
            end
            if (w_fast) r_result <= w_special_val;
        end else if (r_state == S_BUSY && !i_flush) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) r_result <= w_final;
        end
    end

endmodule

// File: tb/tb_mul_div_ctrl.sv
// Self-checking bench for mul_div_ctrl.
// Expected results come from a plain-arithmetic RV32M model.
module tb_mul_div_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic [2:0]  i_func3;
    logic [31:0] i_rs1_data;
    logic [31:0] i_rs2_data;
    logic        i_flush;
    logic        o_stall, o_busy, o_valid;
    logic [31:0] o_result;

    int n_cmp = 0;
    int n_bad = 0;

    mul_div_ctrl #(.FAST_SPECIAL(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_valid    (i_valid),
        .i_func3    (i_func3),
        .i_rs1_data (i_rs1_data),
        .i_rs2_data (i_rs2_data),
        .i_flush    (i_flush),
        .o_stall    (o_stall),
        .o_busy     (o_busy),
        .o_valid    (o_valid),
        .o_result   (o_result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // RV32M semantics in plain integer arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb, ua;
        logic [63:0] p;
        int          ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ia = $signed(a);
        ib = $signed(b);
        case (f)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * longint'({32'd0, b})); return p[63:32]; end
            3'd3: begin p = 64'(ua) * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(ia / ib);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(ia % ib);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                       input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
        return 33;
    endfunction

    // Issue one op, hold i_valid through DONE, check latency/result/stall/single strobe
    task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_r, input int exp_lat);
        int seen = 0;
        int stall_bad = 0;
        @(negedge clk);
        i_valid = 1'b1; i_func3 = f; i_rs1_data = a; i_rs2_data = b;
        #1 check({tag, ".stall_accept"}, 32'(o_stall), 32'd1);
        for (int k = 1; k <= 40 && seen == 0; k++) begin
            @(posedge clk); #1;
            if (o_valid) begin
                seen = k;
                check({tag, ".result"}, o_result, exp_r);
                check({tag, ".stall_done"}, 32'(o_stall), 32'd0);
                i_valid = 1'b0;
            end else if (!o_stall) begin
                stall_bad++;
            end
        end
        i_valid = 1'b0;
        check({tag, ".latency"}, 32'(seen), 32'(exp_lat));
        check({tag, ".stall_gap"}, 32'(stall_bad), 32'd0);
        @(posedge clk); #1;
        check({tag, ".one_strobe"}, 32'(o_valid), 32'd0);
        check({tag, ".idle"}, 32'(o_busy), 32'd0);
    endtask

    initial begin
        logic [2:0]  f;
        logic [31:0] a, b;
        int          r;

        rst_n = 1'b0; i_valid = 1'b0; i_func3 = 3'd0;
        i_rs1_data = 32'd0; i_rs2_data = 32'd0; i_flush = 1'b0;
        #12;
        check("rst.busy",   32'(o_busy),  32'd0);
        check("rst.stall",  32'(o_stall), 32'd0);
        check("rst.valid",  32'(o_valid), 32'd0);
        check("rst.result", o_result,     32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Directed cases with hand-derived results
        do_op("mul_neg",   3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        do_op("mulhu_max", 3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        do_op("mulh_m1",   3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 33);
        do_op("mulhsu_m1", 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        do_op("div_neg",   3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33);
        do_op("rem_neg",   3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33);
        do_op("divu",      3'd5, 32'd100,        32'd7,         32'd14,        33);
        do_op("remu",      3'd7, 32'd100,        32'd7,         32'd2,         33);
        do_op("divu_z",    3'd5, 32'd1234,       32'd0,         32'hFFFF_FFFF, 1);
        do_op("rem_z",     3'd6, 32'hDEAD_BEEF,  32'd0,         32'hDEAD_BEEF, 1);
        do_op("div_ovf",   3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
        do_op("rem_ovf",   3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);

        // Flush while BUSY at counter 10
        @(negedge clk);
        i_valid = 1'b1; i_func3 = 3'd0; i_rs1_data = 32'd9; i_rs2_data = 32'd9;
        repeat (11) @(posedge clk);
        #1 i_flush = 1'b1; i_valid = 1'b0;
        @(posedge clk); #1;
        i_flush = 1'b0;
        check("flush_busy.busy",  32'(o_busy),  32'd0);
        check("flush_busy.valid", 32'(o_valid), 32'd0);
        repeat (25) begin
            @(posedge clk); #1;
            check("flush_busy.no_strobe", 32'(o_valid), 32'd0);
        end

        // Flush together with valid in IDLE: no accept
        @(negedge clk);
        i_valid = 1'b1; i_flush = 1'b1; i_func3 = 3'd0;
        #1 check("flush_idle.stall", 32'(o_stall), 32'd0);
        @(posedge clk); #1;
        check("flush_idle.busy", 32'(o_busy), 32'd0);
        i_valid = 1'b0; i_flush = 1'b0;

        do_op("mul_after_flush", 3'd0, 32'd3, 32'd5, 32'd15, 33);

        // Flush during DONE suppresses the strobe
        @(negedge clk);
        i_valid = 1'b1; i_func3 = 3'd5; i_rs1_data = 32'd5; i_rs2_data = 32'd0;
        @(posedge clk); #1;
        i_flush = 1'b1; i_valid = 1'b0;
        #1 check("flush_done.valid", 32'(o_valid), 32'd0);
        @(posedge clk); #1;
        i_flush = 1'b0;
        check("flush_done.busy", 32'(o_busy), 32'd0);
        check("flush_done.after", 32'(o_valid), 32'd0);

        // Asynchronous reset mid-BUSY
        @(negedge clk);
        i_valid = 1'b1; i_func3 = 3'd1; i_rs1_data = 32'h1234_5678; i_rs2_data = 32'h9ABC_DEF0;
        repeat (5) @(posedge clk);
        #2 i_valid = 1'b0; rst_n = 1'b0;
        #1;
        check("arst.busy",   32'(o_busy),  32'd0);
        check("arst.stall",  32'(o_stall), 32'd0);
        check("arst.valid",  32'(o_valid), 32'd0);
        check("arst.result", o_result,     32'd0);
        @(negedge clk); rst_n = 1'b1;
        do_op("after_reset", 3'd7, 32'd1000, 32'd33, 32'd10, 33);

        // Randomized ops against the reference model
        for (int i = 0; i < 30; i++) begin
            f = 3'($urandom_range(7));
            a = $urandom;
            b = $urandom;
            r = $urandom_range(9);
            if (r == 0) b = 32'd0;
            else if (r == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (r == 2) b = 32'($urandom_range(16));
            else if (r == 3) a = 32'($urandom_range(1000));
            do_op($sformatf("rnd%0d_f%0d", i, f), f, a, b, ref_model(f, a, b), ref_latency(f, a, b));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
